// File: rtl/control_pkg.sv
// Shared encodings and defaults for the microprogrammed control unit.
package control_pkg;

  localparam int AW_DEF = 6;

  typedef logic [AW_DEF-1:0] uaddr_t;

  typedef enum logic [2:0] {
    NS_ENC      = 3'b000,
    NS_FETCH    = 3'b001,
    NS_CR       = 3'b010,
    NS_INC      = 3'b011,
    NS_CR_ENC   = 3'b100,
    NS_CR_INC   = 3'b101,
    NS_CR_FETCH = 3'b110,
    NS_RST      = 3'b111
  } n_sel_e;

  typedef enum logic [1:0] {
    S_MOC  = 2'b00,
    S_COND = 2'b01,
    S_E3   = 2'b10,
    S_E4   = 2'b11
  } s_sel_e;

  localparam uaddr_t FETCH_ADDR_DEF = 6'b000001;
  localparam uaddr_t TRAP_ADDR_DEF  = 6'b111111;

endpackage

// File: rtl/microsequencer_if.sv
// Microstore sequencing fields, status inputs and sequencer outputs.
interface microsequencer_if #(
  parameter int AW = 6
);
  logic [2:0]    N;
  logic          Inv;
  logic [1:0]    S;
  logic [AW-1:0] CR;
  logic          MOC;
  logic          Cond;
  logic          Entrythree;
  logic          Entryfour;
  logic [AW-1:0] EncoderOut;
  logic [AW-1:0] state;
  logic [AW-1:0] IncRegiOut;
  logic          mem_timeout;
  logic          waiting;

  modport master (
    output N, Inv, S, CR, MOC, Cond, Entrythree, Entryfour, EncoderOut,
    input  state, IncRegiOut, mem_timeout, waiting
  );

  modport slave (
    input  N, Inv, S, CR, MOC, Cond, Entrythree, Entryfour, EncoderOut,
    output state, IncRegiOut, mem_timeout, waiting
  );
endinterface

// File: rtl/moc_watchdog.sv
// Counts consecutive MOC-wait cycles; requests a trap and pulses mem_timeout at the limit.
module moc_watchdog #(
  parameter int MOC_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  output logic trap,
  output logic mem_timeout
);

  localparam logic [7:0] LIMIT = 8'(MOC_TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       mem_timeout_q, mem_timeout_d;

  always_comb begin
    trap          = waiting && (cnt_q == LIMIT);
    cnt_d         = 8'd0;
    mem_timeout_d = trap;
    if (waiting && !trap) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

endmodule

// File: rtl/microsequencer.sv
// Registered next-microaddress selection with a MOC-wait watchdog trap.
module microsequencer
  import control_pkg::*;
#(
  parameter int            AW          = 6,
  parameter logic [AW-1:0] FETCH_ADDR  = AW'(FETCH_ADDR_DEF),
  parameter logic [AW-1:0] TRAP_ADDR   = AW'(TRAP_ADDR_DEF),
  parameter int            MOC_TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst_n,
  microsequencer_if.slave    bus
);

  logic [AW-1:0] state_q, state_d;
  logic [AW-1:0] inc_q, inc_d;
  logic [AW-1:0] next_addr;
  logic          sel, t, wait_now, trap;

  always_comb begin
    sel = 1'b0;
    case (s_sel_e'(bus.S))
      S_MOC:   sel = bus.MOC;
      S_COND:  sel = bus.Cond;
      S_E3:    sel = bus.Entrythree;
      S_E4:    sel = bus.Entryfour;
      default: sel = 1'b0;
    endcase
    t = sel ^ bus.Inv;

    next_addr = '0;
    case (n_sel_e'(bus.N))
      NS_ENC:      next_addr = bus.EncoderOut;
      NS_FETCH:    next_addr = FETCH_ADDR;
      NS_CR:       next_addr = bus.CR;
      NS_INC:      next_addr = inc_q;
      NS_CR_ENC:   next_addr = t ? bus.CR : bus.EncoderOut;
      NS_CR_INC:   next_addr = t ? bus.CR : inc_q;
      NS_CR_FETCH: next_addr = t ? bus.CR : FETCH_ADDR;
      NS_RST:      next_addr = '0;
      default:     next_addr = '0;
    endcase

    // Only a MOC-based self-loop counts as a memory wait.
    wait_now = (n_sel_e'(bus.N) == NS_CR_INC) && (s_sel_e'(bus.S) == S_MOC) &&
               t && (bus.CR == state_q);

    state_d = trap ? TRAP_ADDR : next_addr;
    inc_d   = state_d + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      inc_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
    end
  end

  moc_watchdog #(
    .MOC_TIMEOUT (MOC_TIMEOUT)
  ) u_moc_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .waiting     (wait_now),
    .trap        (trap),
    .mem_timeout (bus.mem_timeout)
  );

  assign bus.state      = state_q;
  assign bus.IncRegiOut = inc_q;
  assign bus.waiting    = wait_now;

endmodule

// File: tb/tb_microsequencer.sv
// Table-driven, directed and randomized checks of microsequencer against a behavioural model.
module tb_microsequencer;

  localparam int TO = 15;

  logic clk;
  logic rst_n;

  microsequencer_if #(.AW(6)) bus ();

  microsequencer #(
    .AW          (6),
    .FETCH_ADDR  (6'b000001),
    .TRAP_ADDR   (6'b111111),
    .MOC_TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: microaddress, incremented copy, wait run length, pending pulse.
  int m_state, m_inc, m_cnt, m_to;

  typedef struct {
    logic [2:0] n;
    logic       inv;
    logic [1:0] s;
    logic [5:0] cr;
    logic       moc, cond, e3, e4;
    logic [5:0] enc;
    logic [5:0] exp_state;
    logic [5:0] exp_inc;
    logic       exp_wait;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic [2:0] n, logic inv, logic [1:0] s, logic [5:0] cr,
                              logic moc, logic cond, logic e3, logic [5:0] enc,
                              logic [5:0] es, logic [5:0] ei, logic ew);
    vec_t v;
    v.n = n; v.inv = inv; v.s = s; v.cr = cr;
    v.moc = moc; v.cond = cond; v.e3 = e3; v.e4 = 1'b0; v.enc = enc;
    v.exp_state = es; v.exp_inc = ei; v.exp_wait = ew;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(int n, int inv, int s, int cr, int moc, int cond, int e3, int e4, int enc);
    bus.N          = 3'(n);
    bus.Inv        = 1'(inv);
    bus.S          = 2'(s);
    bus.CR         = 6'(cr);
    bus.MOC        = 1'(moc);
    bus.Cond       = 1'(cond);
    bus.Entrythree = 1'(e3);
    bus.Entryfour  = 1'(e4);
    bus.EncoderOut = 6'(enc);
  endtask

  function automatic int model_t();
    int sel;
    case (bus.S)
      2'd0:    sel = int'(bus.MOC);
      2'd1:    sel = int'(bus.Cond);
      2'd2:    sel = int'(bus.Entrythree);
      default: sel = int'(bus.Entryfour);
    endcase
    return sel ^ int'(bus.Inv);
  endfunction

  function automatic int model_wait();
    return (bus.N == 3'd5 && bus.S == 2'd0 && model_t() == 1 && int'(bus.CR) == m_state) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_inc = 1; m_cnt = 0; m_to = 0;
  endtask

  task automatic model_update();
    int t, nxt, cr, enc;
    t   = model_t();
    cr  = int'(bus.CR);
    enc = int'(bus.EncoderOut);
    case (bus.N)
      3'd0:    nxt = enc;
      3'd1:    nxt = 1;
      3'd2:    nxt = cr;
      3'd3:    nxt = m_inc;
      3'd4:    nxt = t ? cr : enc;
      3'd5:    nxt = t ? cr : m_inc;
      3'd6:    nxt = t ? cr : 1;
      default: nxt = 0;
    endcase
    m_to = 0;
    if (model_wait() == 1) begin
      if (m_cnt == TO - 1) begin
        nxt = 63; m_to = 1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      m_cnt = 0;
    end
    m_state = nxt;
    m_inc   = (nxt + 1) % 64;
  endtask

  // Inputs already driven; check waiting, clock, then check registered outputs vs model.
  task automatic step_model(string tag);
    #1;
    check({tag, ".waiting"}, 8'(bus.waiting), 8'(model_wait()));
    model_update();
    @(posedge clk); #1;
    check({tag, ".state"}, 8'(bus.state), 8'(m_state));
    check({tag, ".inc"}, 8'(bus.IncRegiOut), 8'(m_inc));
    check({tag, ".timeout"}, 8'(bus.mem_timeout), 8'(m_to));
  endtask

  task automatic async_reset_and_release(string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, ".rst_state"}, 8'(bus.state), 8'd0);
    check({tag, ".rst_inc"}, 8'(bus.IncRegiOut), 8'd1);
    check({tag, ".rst_timeout"}, 8'(bus.mem_timeout), 8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    drv(3, 0, 0, 0, 0, 0, 0, 0, 0);

    // Async reset with no clock edge in sight.
    #3 rst_n = 1'b0;
    #1;
    check("reset.state", 8'(bus.state), 8'd0);
    check("reset.inc", 8'(bus.IncRegiOut), 8'd1);
    check("reset.timeout", 8'(bus.mem_timeout), 8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    //              n inv s  cr moc cnd e3 enc  state inc wait
    tbl[0]  = mk(3, 0, 0, 0,  0, 0, 0, 0,   1,  2, 0);
    tbl[1]  = mk(3, 0, 0, 0,  0, 0, 0, 0,   2,  3, 0);
    tbl[2]  = mk(3, 0, 0, 0,  0, 0, 0, 0,   3,  4, 0);
    tbl[3]  = mk(5, 1, 0, 3,  0, 0, 0, 0,   3,  4, 1);
    tbl[4]  = mk(5, 1, 0, 3,  0, 0, 0, 0,   3,  4, 1);
    tbl[5]  = mk(5, 1, 0, 3,  0, 0, 0, 0,   3,  4, 1);
    tbl[6]  = mk(5, 1, 0, 3,  0, 0, 0, 0,   3,  4, 1);
    tbl[7]  = mk(5, 1, 0, 3,  1, 0, 0, 0,   4,  5, 0);
    tbl[8]  = mk(4, 0, 1, 1,  0, 1, 0, 0,   1,  2, 0);
    tbl[9]  = mk(2, 0, 0, 4,  0, 0, 0, 0,   4,  5, 0);
    tbl[10] = mk(4, 0, 1, 1,  0, 0, 0, 10, 10, 11, 0);
    tbl[11] = mk(6, 1, 2, 30, 0, 0, 0, 0,  30, 31, 0);
    tbl[12] = mk(6, 1, 2, 30, 0, 0, 1, 0,   1,  2, 0);
    tbl[13] = mk(5, 0, 1, 1,  0, 1, 0, 0,   1,  2, 0);
    tbl[14] = mk(2, 0, 0, 62, 0, 0, 0, 0,  62, 63, 0);
    tbl[15] = mk(3, 0, 0, 0,  0, 0, 0, 0,  63,  0, 0);
    tbl[16] = mk(3, 0, 0, 0,  0, 0, 0, 0,   0,  1, 0);
    tbl[17] = mk(2, 0, 0, 1,  0, 0, 0, 0,   1,  2, 0);
    tbl[18] = mk(7, 0, 0, 5,  0, 0, 0, 9,   0,  1, 0);
    tbl[19] = mk(0, 0, 0, 5,  0, 0, 0, 33, 33, 34, 0);

    for (int i = 0; i < 20; i++) begin
      drv(tbl[i].n, tbl[i].inv, tbl[i].s, tbl[i].cr, tbl[i].moc, tbl[i].cond,
          tbl[i].e3, tbl[i].e4, tbl[i].enc);
      #1;
      check($sformatf("tbl%0d.waiting", i), 8'(bus.waiting), 8'(tbl[i].exp_wait));
      model_update();
      @(posedge clk); #1;
      check($sformatf("tbl%0d.state", i), 8'(bus.state), 8'(tbl[i].exp_state));
      check($sformatf("tbl%0d.inc", i), 8'(bus.IncRegiOut), 8'(tbl[i].exp_inc));
      check($sformatf("tbl%0d.timeout", i), 8'(bus.mem_timeout), 8'd0);
    end

    // Watchdog: MOC stays low, trap on the 15th wait edge, pulse exactly one cycle.
    drv(2, 0, 0, 5, 0, 0, 0, 0, 0);
    step_model("wd_setup");
    for (int i = 0; i < TO - 1; i++) begin
      drv(5, 1, 0, 5, 0, 0, 0, 0, 0);
      step_model("wd_hold");
      check("wd_hold_state", 8'(bus.state), 8'd5);
    end
    drv(5, 1, 0, 5, 0, 0, 0, 0, 0);
    step_model("wd_trap");
    check("wd_trap_state", 8'(bus.state), 8'd63);
    check("wd_trap_pulse", 8'(bus.mem_timeout), 8'd1);
    drv(3, 0, 0, 0, 0, 0, 0, 0, 0);
    step_model("wd_after");
    check("wd_pulse_end", 8'(bus.mem_timeout), 8'd0);
    check("wd_wrap_state", 8'(bus.state), 8'd0);

    // MOC arrives on the 15th wait cycle: proceeds to CR+1, no trap.
    drv(2, 0, 0, 5, 0, 0, 0, 0, 0);
    step_model("moc_setup");
    for (int i = 0; i < TO - 1; i++) begin
      drv(5, 1, 0, 5, 0, 0, 0, 0, 0);
      step_model("moc_hold");
    end
    drv(5, 1, 0, 5, 1, 0, 0, 0, 0);
    step_model("moc_late");
    check("moc_late_state", 8'(bus.state), 8'd6);
    check("moc_late_pulse", 8'(bus.mem_timeout), 8'd0);

    // Reset while the timeout pulse is high.
    drv(2, 0, 0, 5, 0, 0, 0, 0, 0);
    step_model("rst_pulse_setup");
    for (int i = 0; i < TO; i++) begin
      drv(5, 1, 0, 5, 0, 0, 0, 0, 0);
      step_model("rst_pulse_wait");
    end
    check("rst_pulse_high", 8'(bus.mem_timeout), 8'd1);
    async_reset_and_release("rst_pulse");

    // Reset mid-wait must clear the wait counter.
    drv(2, 0, 0, 5, 0, 0, 0, 0, 0);
    step_model("rst_wait_setup");
    for (int i = 0; i < 10; i++) begin
      drv(5, 1, 0, 5, 0, 0, 0, 0, 0);
      step_model("rst_wait_pre");
    end
    async_reset_and_release("rst_wait");
    drv(2, 0, 0, 5, 0, 0, 0, 0, 0);
    step_model("rst_wait_resetup");
    for (int i = 0; i < TO - 1; i++) begin
      drv(5, 1, 0, 5, 0, 0, 0, 0, 0);
      step_model("rst_wait_post");
    end
    check("rst_wait_no_trap", 8'(bus.state), 8'd5);
    drv(5, 1, 0, 5, 1, 0, 0, 0, 0);
    step_model("rst_wait_release");

    // Randomized: biased towards long MOC waits so traps actually occur.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) != 0) begin
        drv(5, 1, 0, m_state, ($urandom_range(0, 31) == 0) ? 1 : 0,
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 63));
      end else begin
        drv($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
            ($urandom_range(0, 1) == 0) ? m_state : $urandom_range(0, 63),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 63));
      end
      step_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
